// File: rtl/enoc_input_unit.sv
// ENoC router input unit: flit FIFO with XY route computation at enqueue.
// Define ENOC_IU_ERR_EN to add the sticky o_err flow-control error flags.
module enoc_input_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int X_NODES    = 4,
    parameter int Y_NODES    = 4,
    parameter int X_LOC      = 0,
    parameter int Y_LOC      = 0,
    localparam int X_W = (X_NODES > 1) ? $clog2(X_NODES) : 1,
    localparam int Y_W = (Y_NODES > 1) ? $clog2(Y_NODES) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ce,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [X_W-1:0]        i_dest_x,
    input  logic [Y_W-1:0]        i_dest_y,
    input  logic                  i_data_val,
    output logic                  o_en,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_data_val,
    output logic [4:0]            o_output_req,
`ifdef ENOC_IU_ERR_EN
    output logic [1:0]            o_err,
`endif
    input  logic                  i_grant
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL   = CNT_W'(DEPTH);
    localparam logic [X_W-1:0]   X_HERE = X_W'(X_LOC);
    localparam logic [Y_W-1:0]   Y_HERE = Y_W'(Y_LOC);

    // Request bit positions: index 0..4 = c, n, e, s, w
    localparam logic [4:0] REQ_C = 5'b00001;
    localparam logic [4:0] REQ_N = 5'b00010;
    localparam logic [4:0] REQ_E = 5'b00100;
    localparam logic [4:0] REQ_S = 5'b01000;
    localparam logic [4:0] REQ_W = 5'b10000;

    logic [DATA_WIDTH-1:0] data_mem  [DEPTH];
    logic [4:0]            route_mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [4:0]            route;
    logic                  not_empty;
    logic                  wr_en;
    logic                  rd_en;

    // XY dimension-order routing: resolve X fully before moving in Y
    always_comb begin
        route = REQ_C;
        if (i_dest_x > X_HERE)
            route = REQ_E;
        else if (i_dest_x < X_HERE)
            route = REQ_W;
        else if (i_dest_y > Y_HERE)
            route = REQ_N;
        else if (i_dest_y < Y_HERE)
            route = REQ_S;
    end

    assign not_empty = (count != '0);
    assign o_en      = (count < FULL);
    assign wr_en     = ce && i_data_val && o_en;
    assign rd_en     = ce && i_grant && not_empty;

    assign o_data_val   = not_empty;
    assign o_data       = data_mem[rd_ptr];
    assign o_output_req = not_empty ? route_mem[rd_ptr] : 5'b00000;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[wr_ptr]  <= i_data;
            route_mem[wr_ptr] <= route;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !rd_en)
                count <= count + 1'b1;
            else if (rd_en && !wr_en)
                count <= count - 1'b1;
        end
    end

`ifdef ENOC_IU_ERR_EN
    // Sticky: bit0 = send attempted while full, bit1 = grant while empty
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            o_err <= 2'b00;
        end else if (ce) begin
            if (i_data_val && !o_en)
                o_err[0] <= 1'b1;
            if (i_grant && !not_empty)
                o_err[1] <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_enoc_input_unit.sv
// Scoreboard bench for enoc_input_unit at router (1,1) in a 4x4 mesh, DEPTH=4.
module tb_enoc_input_unit;

    localparam logic [4:0] REQ_C = 5'b00001;
    localparam logic [4:0] REQ_N = 5'b00010;
    localparam logic [4:0] REQ_E = 5'b00100;
    localparam logic [4:0] REQ_S = 5'b01000;
    localparam logic [4:0] REQ_W = 5'b10000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ce;
    logic [31:0] i_data;
    logic [1:0]  i_dest_x;
    logic [1:0]  i_dest_y;
    logic        i_data_val;
    logic        o_en;
    logic [31:0] o_data;
    logic        o_data_val;
    logic [4:0]  o_output_req;
    logic        i_grant;
`ifdef ENOC_IU_ERR_EN
    logic [1:0]  o_err;
`endif

    logic [36:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    enoc_input_unit #(
        .DATA_WIDTH(32), .DEPTH(4), .X_NODES(4), .Y_NODES(4), .X_LOC(1), .Y_LOC(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce),
        .i_data(i_data), .i_dest_x(i_dest_x), .i_dest_y(i_dest_y),
        .i_data_val(i_data_val), .o_en(o_en), .o_data(o_data),
        .o_data_val(o_data_val), .o_output_req(o_output_req),
`ifdef ENOC_IU_ERR_EN
        .o_err(o_err),
`endif
        .i_grant(i_grant)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of stimulus; a flit known to be accepted is queued with its hand-derived route
    task automatic applyStimulus(input logic val, input logic [1:0] dx, input logic [1:0] dy,
                                 input logic [31:0] data, input logic grant,
                                 input logic accept, input logic [4:0] req);
        i_data_val = val;
        i_dest_x   = dx;
        i_dest_y   = dy;
        i_data     = data;
        i_grant    = grant;
        if (val && accept)
            exp_q.push_back({req, data});
        tick();
        i_data_val = 1'b0;
        i_grant    = 1'b0;
    endtask

    // Monitor: a flit leaves whenever the DUT presents one and the grant is live
    always @(negedge clk) begin
        if (reset_n && ce && i_grant) begin
            if (o_data_val) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_flit", {32'd0, o_data}, 64'hdead);
                end else begin
                    logic [36:0] e;
                    e = exp_q.pop_front();
                    checkOutput("deq_data", {32'd0, o_data}, {32'd0, e[31:0]});
                    checkOutput("deq_req", {59'd0, o_output_req}, {59'd0, e[36:32]});
                end
            end else if (exp_q.size() != 0) begin
                checkOutput("missing_head_valid", {63'd0, o_data_val}, 64'd1);
            end
        end
    end

    // Directed routes for the streaming phase (dest, route seen from (1,1))
    logic [1:0] sx [5] = '{2'd3, 2'd0, 2'd1, 2'd1, 2'd1};
    logic [1:0] sy [5] = '{2'd2, 2'd3, 2'd3, 2'd0, 2'd1};
    logic [4:0] sr [5] = '{REQ_E, REQ_W, REQ_N, REQ_S, REQ_C};

    initial begin
        reset_n = 1'b0; ce = 1'b1; i_data = '0; i_dest_x = '0; i_dest_y = '0;
        i_data_val = 1'b0; i_grant = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        checkOutput("reset_en", {63'd0, o_en}, 64'd1);
        checkOutput("reset_val", {63'd0, o_data_val}, 64'd0);
        checkOutput("reset_req", {59'd0, o_output_req}, 64'd0);
`ifdef ENOC_IU_ERR_EN
        checkOutput("reset_err", {62'd0, o_err}, 64'd0);
`endif

        // Fill to DEPTH, fifth write while full is dropped
        applyStimulus(1, 2'd2, 2'd1, 32'hA000_0001, 0, 1, REQ_E);
        checkOutput("first_write_visible", {63'd0, o_data_val}, 64'd1);
        applyStimulus(1, 2'd0, 2'd1, 32'hA000_0002, 0, 1, REQ_W);
        applyStimulus(1, 2'd1, 2'd2, 32'hA000_0003, 0, 1, REQ_N);
        applyStimulus(1, 2'd1, 2'd0, 32'hA000_0004, 0, 1, REQ_S);
        checkOutput("full_en", {63'd0, o_en}, 64'd0);
        applyStimulus(1, 2'd1, 2'd1, 32'hA000_0005, 0, 0, REQ_C);
        checkOutput("full_head_req", {59'd0, o_output_req}, {59'd0, REQ_E});
        checkOutput("full_head_data", {32'd0, o_data}, 64'hA000_0001);

        // Drain one per cycle; slot frees after the first grant
        applyStimulus(0, 2'd0, 2'd0, 32'h0, 1, 0, REQ_C);
        checkOutput("en_after_grant", {63'd0, o_en}, 64'd1);
        applyStimulus(0, 2'd0, 2'd0, 32'h0, 1, 0, REQ_C);
        applyStimulus(0, 2'd0, 2'd0, 32'h0, 1, 0, REQ_C);
        applyStimulus(0, 2'd0, 2'd0, 32'h0, 1, 0, REQ_C);
        checkOutput("drained_val", {63'd0, o_data_val}, 64'd0);
        applyStimulus(1, 2'd1, 2'd1, 32'hA000_0005, 0, 1, REQ_C);
        checkOutput("local_req", {59'd0, o_output_req}, {59'd0, REQ_C});
        applyStimulus(0, 2'd0, 2'd0, 32'h0, 1, 0, REQ_C);
        checkOutput("empty_req", {59'd0, o_output_req}, 64'd0);

        // Streaming at count=2: write and grant together for 20 cycles
        applyStimulus(1, 2'd3, 2'd3, 32'hB000_0100, 0, 1, REQ_E);
        applyStimulus(1, 2'd0, 2'd0, 32'hB000_0101, 0, 1, REQ_W);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, sx[i % 5], sy[i % 5], 32'hC000_0000 + 32'(i), 1, 1, sr[i % 5]);
            checkOutput("stream_en", {63'd0, o_en}, 64'd1);
        end
        applyStimulus(0, 2'd0, 2'd0, 32'h0, 1, 0, REQ_C);
        applyStimulus(0, 2'd0, 2'd0, 32'h0, 1, 0, REQ_C);
        checkOutput("stream_drained", {63'd0, o_data_val}, 64'd0);

        // Grant while empty, then a write while full: both ignored
        applyStimulus(0, 2'd0, 2'd0, 32'h0, 1, 0, REQ_C);
        checkOutput("spurious_grant_val", {63'd0, o_data_val}, 64'd0);
        checkOutput("spurious_grant_en", {63'd0, o_en}, 64'd1);
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 2'd2, 2'd2, 32'hD000_0000 + 32'(i), 0, 1, REQ_E);
        applyStimulus(1, 2'd0, 2'd0, 32'hDEAD_BEEF, 0, 0, REQ_W);
        checkOutput("overflow_head", {32'd0, o_data}, 64'hD000_0000);
        checkOutput("overflow_en", {63'd0, o_en}, 64'd0);
`ifdef ENOC_IU_ERR_EN
        checkOutput("err_both", {62'd0, o_err}, 64'd3);
`endif

        // Clock enable low: writes and grants must not move anything
        ce = 1'b0; i_data_val = 1'b1; i_grant = 1'b1; i_data = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("ce_hold_en", {63'd0, o_en}, 64'd0);
            checkOutput("ce_hold_data", {32'd0, o_data}, 64'hD000_0000);
            checkOutput("ce_hold_req", {59'd0, o_output_req}, {59'd0, REQ_E});
        end
        i_data_val = 1'b0; i_grant = 1'b0;
        #1 ce = 1'b1;
        applyStimulus(0, 2'd0, 2'd0, 32'h0, 1, 0, REQ_C);
        checkOutput("ce_resume_en", {63'd0, o_en}, 64'd1);
`ifdef ENOC_IU_ERR_EN
        checkOutput("err_sticky", {62'd0, o_err}, 64'd3);
`endif

        // Reset with three flits buffered discards them
        reset_n = 1'b0;
        exp_q.delete();
        tick();
        reset_n = 1'b1;
        checkOutput("midreset_val", {63'd0, o_data_val}, 64'd0);
        checkOutput("midreset_req", {59'd0, o_output_req}, 64'd0);
        checkOutput("midreset_en", {63'd0, o_en}, 64'd1);
`ifdef ENOC_IU_ERR_EN
        checkOutput("midreset_err", {62'd0, o_err}, 64'd0);
`endif
        applyStimulus(1, 2'd0, 2'd3, 32'hE000_0001, 0, 1, REQ_W);
        checkOutput("post_reset_req", {59'd0, o_output_req}, {59'd0, REQ_W});
        checkOutput("post_reset_data", {32'd0, o_data}, 64'hE000_0001);
        applyStimulus(0, 2'd0, 2'd0, 32'h0, 1, 0, REQ_C);

        checkOutput("final_val", {63'd0, o_data_val}, 64'd0);
        checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
